// File: rtl/vend_ctrl_param_if.sv
// Bundle of coin, hopper and display signals between the vending controller and its environment.
// The slave side is the controller; the master side drives coins and hopper status.
interface vend_ctrl_param_if #(
    parameter int CW = 8
);
    logic          c5;
    logic          c10;
    logic          c25;
    logic          cancel;
    logic          item_taken;
    logic          chg_ready;
    logic          dispense;
    logic          chg_valid;
    logic [1:0]    chg_coin;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic [CW-1:0] change_due;
    logic [1:0]    state;

    modport master (
        output c5, c10, c25, cancel, item_taken, chg_ready,
        input  dispense, chg_valid, chg_coin, coin_reject, credit, change_due, state
    );

    modport slave (
        input  c5, c10, c25, cancel, item_taken, chg_ready,
        output dispense, chg_valid, chg_coin, coin_reject, credit, change_due, state
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Vending controller: accumulates coin credit, releases one item at PRICE and pays change
// back greedily (20/10/5) through a ready/valid coin hopper.
module vend_ctrl_param #(
    parameter int CW         = 8,
    parameter int PRICE      = 20,
    parameter int MAX_CREDIT = 95
) (
    input logic clk,
    input logic reset,
    vend_ctrl_param_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        CHANGE  = 2'b11
    } state_t;

    localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW:0] MAX_W   = (CW+1)'(MAX_CREDIT);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] change_q, change_d;
    logic          dispense_q, dispense_d;
    logic          reject_q, reject_d;

    logic [1:0]    n_coins;
    logic          any_coin;
    logic          accept;
    logic [CW:0]   sum;
    logic [1:0]    coin_code;

    // Value of a single valid coin; only meaningful when exactly one pulse is high.
    function automatic logic [CW:0] coin_value(input logic p5, input logic p10, input logic p25);
        logic [CW:0] v;
        v = '0;
        if (p25)      v = (CW+1)'(25);
        else if (p10) v = (CW+1)'(10);
        else if (p5)  v = (CW+1)'(5);
        return v;
    endfunction

    function automatic logic [1:0] change_code(input logic [CW-1:0] due);
        logic [1:0] code;
        code = 2'b00;
        if (due >= CW'(20))      code = 2'b11;
        else if (due >= CW'(10)) code = 2'b10;
        else if (due >= CW'(5))  code = 2'b01;
        return code;
    endfunction

    function automatic logic [CW-1:0] code_value(input logic [1:0] code);
        logic [CW-1:0] v;
        case (code)
            2'b11:   v = CW'(20);
            2'b10:   v = CW'(10);
            2'b01:   v = CW'(5);
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        n_coins    = {1'b0, bus.c5} + {1'b0, bus.c10} + {1'b0, bus.c25};
        any_coin   = (n_coins != 2'd0);
        // Extra bit keeps the ceiling compare from wrapping.
        sum        = {1'b0, credit_q} + coin_value(bus.c5, bus.c10, bus.c25);
        coin_code  = change_code(change_q);
        accept     = 1'b0;
        state_d    = state_q;
        credit_d   = credit_q;
        change_d   = change_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (state_q == COLLECT && bus.cancel) begin
                    change_d = credit_q;
                    credit_d = '0;
                    state_d  = CHANGE;
                end else if (n_coins == 2'd1 && sum <= MAX_W) begin
                    accept   = 1'b1;
                    credit_d = sum[CW-1:0];
                    if (sum >= PRICE_W) begin
                        change_d = sum[CW-1:0] - PRICE_W[CW-1:0];
                        state_d  = VEND;
                    end else begin
                        state_d  = COLLECT;
                    end
                end
            end
            VEND: begin
                if (bus.item_taken) begin
                    credit_d = '0;
                    state_d  = (change_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (bus.chg_ready) begin
                    change_d = change_q - code_value(coin_code);
                    if (change_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        reject_d   = any_coin && !accept;
        dispense_d = (state_d == VEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            dispense_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            dispense_q <= dispense_d;
            reject_q   <= reject_d;
        end
    end

    // Hopper request is derived from registered state only, so it holds while chg_ready is low.
    assign bus.chg_valid   = (state_q == CHANGE);
    assign bus.chg_coin    = (state_q == CHANGE) ? coin_code : 2'b00;
    assign bus.dispense    = dispense_q;
    assign bus.coin_reject = reject_q;
    assign bus.credit      = credit_q;
    assign bus.change_due  = change_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param at PRICE=20, MAX_CREDIT=95: directed scenarios followed by
// random coin/hopper traffic, all checked against a cents-level reference model.
module tb_vend_ctrl_param;
    localparam int CW         = 8;
    localparam int PRICE      = 20;
    localparam int MAX_CREDIT = 95;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    // Reference model: 0 idle, 1 collecting, 2 vending, 3 paying change.
    int m_state, m_credit, m_change, m_disp, m_rej;

    vend_ctrl_param_if #(.CW(CW)) bus ();

    vend_ctrl_param #(.CW(CW), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp))
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int greedy(input int due);
        if (due >= 20) return 20;
        if (due >= 10) return 10;
        if (due >= 5)  return 5;
        return 0;
    endfunction

    function automatic int coin_code_of(input int cents);
        return (cents == 20) ? 3 : (cents == 10) ? 2 : (cents == 5) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_change = 0; m_disp = 0; m_rej = 0;
    endtask

    task automatic model_edge();
        int  coins, val, nst, ncr, nch;
        bit  acc;
        coins = int'(bus.c5) + int'(bus.c10) + int'(bus.c25);
        val   = bus.c25 ? 25 : bus.c10 ? 10 : bus.c5 ? 5 : 0;
        nst = m_state; ncr = m_credit; nch = m_change; acc = 0;
        if (m_state == 1 && bus.cancel) begin
            nch = m_credit; ncr = 0; nst = 3;
        end else if (m_state <= 1) begin
            if (coins == 1 && m_credit + val <= MAX_CREDIT) begin
                acc = 1;
                ncr = m_credit + val;
                if (ncr >= PRICE) begin
                    nst = 2; nch = ncr - PRICE;
                end else begin
                    nst = 1;
                end
            end
        end else if (m_state == 2) begin
            if (bus.item_taken) begin
                ncr = 0; nst = (m_change > 0) ? 3 : 0;
            end
        end else if (bus.chg_ready) begin
            nch = m_change - greedy(m_change);
            if (nch == 0) nst = 0;
        end
        m_rej    = (coins > 0 && !acc) ? 1 : 0;
        m_state  = nst;
        m_credit = ncr;
        m_change = nch;
        m_disp   = (nst == 2) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), m_state);
        chk("credit", 32'(bus.credit), m_credit);
        chk("change_due", 32'(bus.change_due), m_change);
        chk("dispense", 32'(bus.dispense), m_disp);
        chk("coin_reject", 32'(bus.coin_reject), m_rej);
        chk("chg_valid", 32'(bus.chg_valid), (m_state == 3) ? 1 : 0);
        chk("chg_coin", 32'(bus.chg_coin), (m_state == 3) ? coin_code_of(greedy(m_change)) : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step(input bit a5, input bit a10, input bit a25,
                        input bit can, input bit it, input bit rdy);
        bus.c5 = a5; bus.c10 = a10; bus.c25 = a25;
        bus.cancel = can; bus.item_taken = it; bus.chg_ready = rdy;
        cycle();
    endtask

    initial begin
        int r;
        n_cmp = 0; n_err = 0;
        bus.c5 = 0; bus.c10 = 0; bus.c25 = 0;
        bus.cancel = 0; bus.item_taken = 0; bus.chg_ready = 0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Overpay with a quarter.
        step(0, 0, 1, 0, 0, 0);
        chk("ovp_credit", 32'(bus.credit), 25);
        chk("ovp_change", 32'(bus.change_due), 5);
        chk("ovp_dispense", 32'(bus.dispense), 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("ovp_coin", 32'(bus.chg_coin), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("ovp_idle", 32'(bus.state), 0);

        // Multi-coin refusal in idle, then exact pay with a late quarter refused in VEND.
        step(1, 1, 0, 0, 0, 0);
        chk("multi_rej", 32'(bus.coin_reject), 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("exact_state", 32'(bus.state), 2);
        step(0, 0, 1, 1, 0, 0);
        chk("vend_rej", 32'(bus.coin_reject), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("exact_valid", 32'(bus.chg_valid), 0);

        // Refund with hopper stall, and cancel-with-coin in COLLECT.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("refund_due", 32'(bus.change_due), 15);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("stall_coin", 32'(bus.chg_coin), 2);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("stall_due", 32'(bus.change_due), 5);
        step(0, 0, 0, 1, 0, 1);
        chk("refund_credit", 32'(bus.credit), 0);

        // Asynchronous reset in the middle of paying change.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        chk("post_rst_credit", 32'(bus.credit), 5);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            step(r == 0 || r == 3, r == 1 || r == 3 || r == 4, r == 2 || r == 4,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
